// File: rtl/register_file_mp_pkg.sv
// Shared types and defaults for the multi-port register file.
package register_file_mp_pkg;

   localparam int XLEN_DEF     = 32;
   localparam int NUM_REGS_DEF = 32;
   localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);
   localparam int ZERO_REG     = 0;

   typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
   typedef logic [XLEN_DEF-1:0]   xlen_t;

endpackage

// File: rtl/register_file_mp_wr_arb.sv
// Resolves, per register, whether any write port targets it this cycle and
// which data wins (highest-index enabled port); x0 is never a target.
module register_file_mp_wr_arb
   import register_file_mp_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter int NUM_REGS   = NUM_REGS_DEF,
   parameter int NUM_WR     = 1,
   localparam int ADDR_W    = $clog2(NUM_REGS)
) (
   input  logic [NUM_WR-1:0]                wr_en,
   input  logic [NUM_WR-1:0][ADDR_W-1:0]    wr_reg,
   input  logic [NUM_WR-1:0][XLEN-1:0]      wr_data,
   output logic [NUM_REGS-1:0]              hit,
   output logic [NUM_REGS-1:0][XLEN-1:0]    hit_data
);

   // Ascending scan: a later (higher-index) port overwrites earlier ones.
   always_comb begin
      hit      = '0;
      hit_data = '0;
      for (int unsigned p = 0; p < NUM_WR; p++) begin
         if (wr_en[p] && (wr_reg[p] != ADDR_W'(ZERO_REG))) begin
            hit[wr_reg[p]]      = 1'b1;
            hit_data[wr_reg[p]] = wr_data[p];
         end
      end
   end

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file with synchronous clear, optional
// write-to-read bypass and a per-register busy scoreboard.
module register_file_mp
   import register_file_mp_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter int NUM_REGS   = NUM_REGS_DEF,
   parameter int NUM_RD     = 2,
   parameter int NUM_WR     = 1,
   parameter bit BYPASS     = 1'b0,
   localparam int ADDR_W    = $clog2(NUM_REGS)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_WR-1:0]               wr_en,
   input  logic [NUM_WR-1:0][ADDR_W-1:0]   wr_reg,
   input  logic [NUM_WR-1:0][XLEN-1:0]     wr_data,
   input  logic [NUM_RD-1:0][ADDR_W-1:0]   rd_reg,
   output logic [NUM_RD-1:0][XLEN-1:0]     rd_data,
   output logic [NUM_RD-1:0]               rd_busy,
   input  logic                            busy_set_en,
   input  logic [ADDR_W-1:0]               busy_set_reg
);

   logic [NUM_WR-1:0]             wr_en_g;
   logic [NUM_REGS-1:0]           hit;
   logic [NUM_REGS-1:0][XLEN-1:0] hit_data;
   logic [NUM_REGS-1:0][XLEN-1:0] mem;
   logic [NUM_REGS-1:0]           busy;
   logic [NUM_REGS-1:0]           set_hit;

   // Gating enables during reset drops the writes and suppresses bypass at once.
   assign wr_en_g = rst ? '0 : wr_en;

   register_file_mp_wr_arb #(
      .XLEN     (XLEN),
      .NUM_REGS (NUM_REGS),
      .NUM_WR   (NUM_WR)
   ) u_wr_arb (
      .wr_en    (wr_en_g),
      .wr_reg   (wr_reg),
      .wr_data  (wr_data),
      .hit      (hit),
      .hit_data (hit_data)
   );

   always_comb begin
      set_hit = '0;
      if (busy_set_en && !rst && (busy_set_reg != ADDR_W'(ZERO_REG)))
         set_hit[busy_set_reg] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem <= '0;
      end else begin
         for (int unsigned r = 1; r < NUM_REGS; r++)
            if (hit[r]) mem[r] <= hit_data[r];
      end
   end

   // Set beats clear: issue has allocated a newer producer for that register.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else begin
         for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (set_hit[r])  busy[r] <= 1'b1;
            else if (hit[r]) busy[r] <= 1'b0;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int unsigned j = 0; j < NUM_RD; j++) begin
         rd_data[j] = mem[rd_reg[j]];
         rd_busy[j] = busy[rd_reg[j]];
         if (BYPASS && hit[rd_reg[j]]) begin
            rd_data[j] = hit_data[rd_reg[j]];
            if (!set_hit[rd_reg[j]]) rd_busy[j] = 1'b0;
         end
         if (rd_reg[j] == ADDR_W'(ZERO_REG)) begin
            rd_data[j] = '0;
            rd_busy[j] = 1'b0;
         end
      end
   end

endmodule
